alu_serial: RTL and testbench
=============================

# alu_serial

Bit-serial, handshaked implementation of the team's 4-bit ALU operation set (AND, OR, ADD, AND-NOT, OR-NOT, SUB, SLT). It is the responder on the operand/opcode interface that the ALU test driver issues on: it accepts one operation, computes it one bit per clock LSB-first through a single full-adder slice with a carry register, and presents the result behind a valid/ready output port. It trades throughput for area and sits between an operation source (driver or controller) and a result consumer.

## Interface
- WIDTH, 4, operand/result width in bits (≥2); bit counter is clog2(WIDTH) bits
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept; high only in IDLE
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- op  input  3  000 AND, 001 OR, 010 ADD, 100 A&~B, 101 A|~B, 110 SUB, 111 SLT, 011 illegal
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- op_err  output  1  registered; 1 when the completed op was 011

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch a, b, op into shift registers; bit counter ← 0; carry ← 1 if op∈{110,111} else 0; op_err ← (op==011); go to RUN.
- RUN: each cycle process bit i = counter. b_eff = op[2] ? ~b[i] : b[i]. Bit result: op[1:0]=00 → a&b_eff; 01 → a|b_eff; 10/11 → a^b_eff^carry. Carry ← majority(a, b_eff, carry). Shift the result bit in at the MSB end so the register holds the result LSB-aligned after WIDTH shifts.
- On bit WIDTH-1: compute v = carry_in_to_msb XOR carry_out. For SLT, result = {WIDTH-1 zeros, sum_msb XOR v}, correct even when A−B overflows. For op 011, result = 0. Go to DONE.
- DONE: out_valid=1. Hold result and op_err stable until out_valid&&out_ready, then go to IDLE.
- Arithmetic wraps modulo 2^WIDTH. No overflow or carry outputs apart from their use inside SLT.
- in_valid is ignored outside IDLE. The source must hold a, b, op only for the accepting cycle.

## Timing
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, result=0, op_err=0, counter=0, carry=0. An in-flight operation is discarded and no result is produced.
- Reset release is synchronous in effect: the first accept can occur on the first rising edge after rst_n goes high.
- Latency: accept on edge E → RUN edges E+1..E+WIDTH → out_valid high after edge E+WIDTH (WIDTH cycles).
- Output handshake completes on edge D. in_ready rises after D. The next accept can occur no earlier than D+1.
- There is no same-cycle result drain and input accept.
- Minimum period per op: WIDTH+2 cycles.
- out_ready held low: DONE persists indefinitely and result/op_err do not change.
- result and op_err are register outputs. in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.

## Test plan
- ADD 3+4, out_ready=1 → out_valid exactly 4 cycles after accept, result=0111, op_err=0; in_ready back high the cycle after drain.
- SUB −8−1 and ADD 7+1 → result=0111 and result=1000 (wrap-around). AND 0101&0011 → 0001. A&~B 0101,0011 → 0100. A|~B 0000,1111 → 0000.
- SLT −8<7 → 0001; 7<−8 → 0000 (overflow case); −1<−1 → 0000; −2<−1 → 0001.
- op=011, a=5, b=3 → result=0000, op_err=1, normal latency; the next legal op clears op_err.
- Back-pressure: out_ready low for 3 cycles in DONE → result stable, in_ready=0, in_valid pulses ignored; raise out_ready → single drain, then IDLE.
- Reset mid-RUN (rst_n low after 2 RUN cycles of ADD 7+7) → all outputs at reset values immediately with no clock edge needed; after release, ADD 1+1 → 0010 with no residue from the discarded operation.
- Exhaustive: all 7 legal ops × all 256 (a,b) pairs, back-to-back issues, compared against a behavioural model.

Source files
------------

// File: rtl/alu_serial.sv
// Bit-serial 4-op-class ALU: one full-adder slice and a carry register process
// the operands LSB-first, with a valid/ready handshake on both sides.
module alu_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             op_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic last, b_eff, sum, carry_nx, bit_res, ovf;

    // Single full-adder slice; the operand shift registers present bit i at [0].
    always_comb begin
        last     = (cnt == CW'(WIDTH - 1));
        b_eff    = op_r[2] ? ~b_sh[0] : b_sh[0];
        sum      = a_sh[0] ^ b_eff ^ carry;
        carry_nx = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
        ovf      = carry ^ carry_nx;
        case (op_r[1:0])
            2'b00:   bit_res = a_sh[0] & b_eff;
            2'b01:   bit_res = a_sh[0] | b_eff;
            default: bit_res = sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            op_r   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
            op_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        op_r   <= op;
                        cnt    <= '0;
                        carry  <= op[2] & op[1];
                        op_err <= (op == 3'b011);
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nx;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    // SLT sign is sum_msb ^ overflow, so it stays correct when A-B overflows.
                    if (last && op_r == 3'b111)
                        result <= WIDTH'(sum ^ ovf);
                    else if (last && op_r == 3'b011)
                        result <= '0;
                    else
                        result <= {bit_res, result[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Directed and exhaustive checks for alu_serial: table vectors, handshake
// timing, back-pressure and asynchronous reset during an operation.
module tb_alu_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         op_err;

    int passed = 0;
    int total  = 0;

    alu_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         err;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] o);
        case (o)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b100:  return x & ~y;
            3'b101:  return x | ~y;
            3'b110:  return x - y;
            3'b111:  return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            default: return '0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer an op as soon as in_ready is seen; returns after the accepting edge.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] xo);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        op = xo;
        step();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 3'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] xo,
                          input logic [W-1:0] er, input logic ee, input string name,
                          input bit full);
        int n;
        issue(xa, xb, xo);
        wait_valid(n);
        if (full || n != W) chk({name, "_latency"}, 32'(n), 32'(W));
        chk({name, "_result"}, 32'(result), 32'(er));
        chk({name, "_err"}, 32'(op_err), 32'(ee));
        step();
        if (full) begin
            chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
            chk({name, "_valid_after"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int n;
        logic [2:0] legal_ops[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

        vecs.push_back('{4'd3,    4'd4,    3'b010, 4'b0111, 1'b0, "add_3_4"});
        vecs.push_back('{4'b1000, 4'b0001, 3'b110, 4'b0111, 1'b0, "sub_m8_1"});
        vecs.push_back('{4'd7,    4'd1,    3'b010, 4'b1000, 1'b0, "add_7_1"});
        vecs.push_back('{4'b0101, 4'b0011, 3'b000, 4'b0001, 1'b0, "and"});
        vecs.push_back('{4'b0101, 4'b0011, 3'b001, 4'b0111, 1'b0, "or"});
        vecs.push_back('{4'b0101, 4'b0011, 3'b100, 4'b0100, 1'b0, "andn"});
        vecs.push_back('{4'b0000, 4'b1111, 3'b101, 4'b0000, 1'b0, "orn"});
        vecs.push_back('{4'b1000, 4'b0111, 3'b111, 4'b0001, 1'b0, "slt_m8_7"});
        vecs.push_back('{4'b0111, 4'b1000, 3'b111, 4'b0000, 1'b0, "slt_7_m8"});
        vecs.push_back('{4'b1111, 4'b1111, 3'b111, 4'b0000, 1'b0, "slt_m1_m1"});
        vecs.push_back('{4'b1110, 4'b1111, 3'b111, 4'b0001, 1'b0, "slt_m2_m1"});
        vecs.push_back('{4'd5,    4'd3,    3'b011, 4'b0000, 1'b1, "illegal"});
        vecs.push_back('{4'd1,    4'd2,    3'b010, 4'b0011, 1'b0, "clear_err"});

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_op_err", 32'(op_err), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].err, vecs[i].name, 1'b1);

        // Back-pressure: hold DONE for 3 cycles while pulsing in_valid.
        out_ready = 1'b0;
        issue(4'd2, 4'd3, 3'b010);
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'(W));
        for (int unsigned k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 4'd9;
            b = 4'd9;
            op = 3'b001;
            step();
            chk("bp_result", 32'(result), 32'd5);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(in_ready), 32'd1);
        step();
        chk("bp_no_accept", 32'(in_ready), 32'd1);

        // Asynchronous reset two RUN cycles into ADD 7+7.
        issue(4'd7, 4'd7, 3'b010);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_op_err", 32'(op_err), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        run_op(4'd1, 4'd1, 3'b010, 4'b0010, 1'b0, "post_rst_add", 1'b1);

        // Exhaustive sweep, back-to-back issues against the behavioural model.
        foreach (legal_ops[k])
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run_op(W'(x), W'(y), legal_ops[k], model(W'(x), W'(y), legal_ops[k]),
                           1'b0, $sformatf("ex_op%0d_%0d_%0d", legal_ops[k], x, y), 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
